// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one serial slave port among NUM_MASTERS bit-serial masters.
// Grants one owner per transaction, inserts a release cycle between owners and reclaims the bus via a watchdog.

module bus_arbiter_chk #(
    parameter int NUM_MASTERS = 2
) (
    input logic                   clk,
    input logic                   rstn,
    input logic [NUM_MASTERS-1:0] grant,
    input logic                   busy,
    input logic                   timeout
);

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rstn) $onehot0(grant));
    a_timeout_no_grant: assert property (@(posedge clk) disable iff (!rstn) timeout |-> (grant == {NUM_MASTERS{1'b0}}));
    a_busy_has_grant: assert property (@(posedge clk) disable iff (!rstn) busy |-> (grant != {NUM_MASTERS{1'b0}}));

endmodule

module bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 64,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] req,
    output logic [NUM_MASTERS-1:0] grant,
    input  logic [NUM_MASTERS-1:0] m_mode,
    input  logic [NUM_MASTERS-1:0] m_wr_bus,
    input  logic [NUM_MASTERS-1:0] m_valid,
    input  logic [NUM_MASTERS-1:0] m_ready,
    output logic                   m_rd_bus,
    output logic [NUM_MASTERS-1:0] m_slave_ready,
    output logic [NUM_MASTERS-1:0] m_slave_valid,
    output logic                   mode,
    output logic                   wr_bus,
    output logic                   master_valid,
    output logic                   master_ready,
    input  logic                   rd_bus,
    input  logic                   slave_ready,
    input  logic                   slave_valid,
    output logic [IDX_W-1:0]       owner,
    output logic                   busy,
    output logic                   timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic WD_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   timeout_q, timeout_d;
    logic                   sel_found_s;
    logic [IDX_W-1:0]       sel_idx_s;
    logic                   wd_fire_s;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return IDX_W'(sum % NUM_MASTERS);
    endfunction

    // Search downward so the lowest offset from the pointer wins; the pointer sits just past the last owner.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = {IDX_W{1'b0}};
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            sel_found_s = sel_found_s | req[rr_idx(rr_ptr_q, i)];
            sel_idx_s   = req[rr_idx(rr_ptr_q, i)] ? rr_idx(rr_ptr_q, i) : sel_idx_s;
        end
    end

    assign wd_fire_s = WD_EN && (cnt_q == CNT_LAST);

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            grant_q   <= {NUM_MASTERS{1'b0}};
            owner_q   <= {IDX_W{1'b0}};
            rr_ptr_q  <= {IDX_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found_s) state_d = ST_BUSY;
                else             state_d = ST_IDLE;
            end
            ST_BUSY: begin
                if (!req[owner_q] || wd_fire_s) state_d = ST_RELEASE;
                else                            state_d = ST_BUSY;
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Next values of grant, owner, pointer, watchdog and status flags.
    always_comb begin
        grant_d   = grant_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        busy_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_found_s) begin
                    grant_d            = {NUM_MASTERS{1'b0}};
                    grant_d[sel_idx_s] = 1'b1;
                    owner_d            = sel_idx_s;
                    rr_ptr_d           = rr_idx(sel_idx_s, 1);
                    cnt_d              = {CNT_W{1'b0}};
                    busy_d             = 1'b1;
                end else begin
                    grant_d = {NUM_MASTERS{1'b0}};
                end
            end
            ST_BUSY: begin
                if (state_d == ST_RELEASE) begin
                    grant_d   = {NUM_MASTERS{1'b0}};
                    cnt_d     = {CNT_W{1'b0}};
                    timeout_d = req[owner_q];
                end else begin
                    cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    busy_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                grant_d = {NUM_MASTERS{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
            default: begin
                grant_d  = {NUM_MASTERS{1'b0}};
                owner_d  = {IDX_W{1'b0}};
                rr_ptr_d = {IDX_W{1'b0}};
                cnt_d    = {CNT_W{1'b0}};
            end
        endcase
    end

    // Forward mux keyed on the registered grant so a non-owner never reaches the slave.
    always_comb begin
        if (grant_q != {NUM_MASTERS{1'b0}}) begin
            mode         = m_mode[owner_q];
            wr_bus       = m_wr_bus[owner_q];
            master_valid = m_valid[owner_q];
            master_ready = m_ready[owner_q];
        end else begin
            mode         = 1'b0;
            wr_bus       = 1'b0;
            master_valid = 1'b0;
            master_ready = 1'b0;
        end
    end

    assign m_rd_bus      = rd_bus;
    assign m_slave_ready = {NUM_MASTERS{slave_ready}} & grant_q;
    assign m_slave_valid = {NUM_MASTERS{slave_valid}} & grant_q;
    assign grant         = grant_q;
    assign owner         = owner_q;
    assign busy          = busy_q;
    assign timeout       = timeout_q;

    bus_arbiter_chk #(.NUM_MASTERS(NUM_MASTERS)) u_chk (
        .clk     (clk),
        .rstn    (rstn),
        .grant   (grant_q),
        .busy    (busy_q),
        .timeout (timeout_q)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table for routing/arbitration plus sequences for gaps, watchdog and async reset.

module tb_bus_arbiter;

    logic       clk;
    logic       rstn;
    logic [1:0] req, grant, m_mode, m_wr_bus, m_valid, m_ready;
    logic       m_rd_bus;
    logic [1:0] m_slave_ready, m_slave_valid;
    logic       mode, wr_bus, master_valid, master_ready;
    logic       rd_bus, slave_ready, slave_valid;
    logic [0:0] owner;
    logic       busy, timeout;

    int total = 0;
    int bad   = 0;

    bus_arbiter #(.NUM_MASTERS(2), .TIMEOUT(64)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req           (req),
        .grant         (grant),
        .m_mode        (m_mode),
        .m_wr_bus      (m_wr_bus),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_rd_bus      (m_rd_bus),
        .m_slave_ready (m_slave_ready),
        .m_slave_valid (m_slave_valid),
        .mode          (mode),
        .wr_bus        (wr_bus),
        .master_valid  (master_valid),
        .master_ready  (master_ready),
        .rd_bus        (rd_bus),
        .slave_ready   (slave_ready),
        .slave_valid   (slave_valid),
        .owner         (owner),
        .busy          (busy),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  req;
        logic [1:0]  mode;
        logic [1:0]  wr;
        logic [1:0]  valid;
        logic [1:0]  ready;
        logic        rd;
        logic        sr;
        logic        sv;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        req = 2'b00; m_mode = 2'b00; m_wr_bus = 2'b00; m_valid = 2'b00; m_ready = 2'b00;
        rd_bus = 1'b0; slave_ready = 1'b0; slave_valid = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    function automatic logic [13:0] outs();
        return {grant, mode, wr_bus, master_valid, master_ready, m_rd_bus,
                m_slave_ready, m_slave_valid, owner, busy, timeout};
    endfunction

    initial begin
        int         n;
        int         gap;
        logic [1:0] exp_g;
        logic [7:0] pat;
        logic [7:0] wr_cap;
        logic [7:0] rd_cap;

        // Row: req mode wr valid ready rd sr sv | grant mode wr mv mr rd msr msv owner busy tmo
        vecs[0]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 14'b00_0000_1_00_00_000};
        vecs[1]  = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b01, 1'b0, 1'b1, 1'b1, 14'b01_0101_0_01_01_010};
        vecs[2]  = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b10, 1'b0, 1'b0, 1'b1, 14'b01_1010_0_00_01_010};
        vecs[3]  = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b11, 1'b1, 1'b1, 1'b1, 14'b00_0000_1_00_00_000};
        vecs[4]  = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 14'b00_0000_0_00_00_000};
        vecs[5]  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 14'b10_1110_1_00_10_110};
        vecs[6]  = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b11, 1'b0, 1'b1, 1'b0, 14'b10_0001_0_10_00_110};
        vecs[7]  = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 14'b00_0000_1_00_00_100};
        vecs[8]  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 14'b00_0000_0_00_00_100};
        vecs[9]  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 14'b01_1111_0_01_01_010};
        vecs[10] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 14'b00_0000_0_00_00_000};
        vecs[11] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 14'b00_0000_0_00_00_000};

        rstn = 1'b0;
        clear_inputs();
        do_reset();
        chk("reset_state", {grant, busy, owner, timeout, master_valid}, 32'h0);

        for (int i = 0; i < 12; i++) begin
            req = vecs[i].req; m_mode = vecs[i].mode; m_wr_bus = vecs[i].wr;
            m_valid = vecs[i].valid; m_ready = vecs[i].ready;
            rd_bus = vecs[i].rd; slave_ready = vecs[i].sr; slave_valid = vecs[i].sv;
            step();
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Master 1 byte transfer after master 0: forwarded write bits and returned read bits.
        do_reset();
        req = 2'b11;
        step();
        chk("rb_first_grant", grant, 2'b01);
        req = 2'b10;
        step();
        step();
        step();
        chk("rb_second_grant", grant, 2'b10);
        pat = 8'hA5;
        wr_cap = 8'h00;
        rd_cap = 8'h00;
        for (int b = 7; b >= 0; b--) begin
            m_wr_bus = {pat[b], ~pat[b]};
            m_valid = 2'b11;
            rd_bus = pat[b];
            slave_valid = 1'b1;
            slave_ready = 1'b1;
            step();
            wr_cap = {wr_cap[6:0], wr_bus};
            rd_cap = {rd_cap[6:0], m_rd_bus};
            chk("rb_slave_valid_route", {m_slave_valid, m_slave_ready}, 4'b1010);
        end
        chk("rb_write_byte", wr_cap, 8'hA5);
        chk("rb_read_byte", rd_cap, 8'hA5);

        // Alternation with a two-cycle zero-grant gap between owners.
        do_reset();
        req = 2'b11;
        step();
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk($sformatf("alt_grant%0d", k), grant, exp_g);
            repeat (25) step();
            chk($sformatf("alt_hold%0d", k), {grant, busy}, {exp_g, 1'b1});
            req = req & ~grant;
            step();
            req = 2'b11;
            gap = 0;
            while (grant == 2'b00 && gap < 10) begin
                gap++;
                step();
            end
            chk($sformatf("alt_gap%0d", k), gap, 2);
        end

        // Watchdog: master 1 alone, then with master 0 also requesting.
        do_reset();
        req = 2'b10;
        step();
        chk("wd_grant", grant, 2'b10);
        n = 0;
        while (timeout !== 1'b1 && n < 200) begin
            n++;
            step();
        end
        chk("wd_latency", n, 64);
        chk("wd_grant_dropped", {grant, busy}, 3'b000);
        step();
        chk("wd_pulse_end", {timeout, grant}, 3'b000);
        step();
        chk("wd_regrant_alone", grant, 2'b10);
        req = 2'b11;
        n = 0;
        while (timeout !== 1'b1 && n < 200) begin
            n++;
            step();
        end
        chk("wd_latency2", n, 64);
        step();
        chk("wd_gap2", grant, 2'b00);
        step();
        chk("wd_other_wins", grant, 2'b01);

        // Asynchronous reset in the middle of a transaction.
        do_reset();
        req = 2'b01;
        m_valid = 2'b01;
        step();
        chk("ar_pre", {grant, master_valid, busy}, 4'b0111);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_async_drop", {grant, master_valid, busy}, 4'b0000);
        step();
        rstn = 1'b1;
        step();
        chk("ar_regrant", {grant, master_valid, busy}, 4'b0111);
        req = 2'b00;
        step();
        chk("ar_release", {grant, master_valid, busy}, 4'b0000);
        step();
        chk("ar_idle", {grant, busy, timeout}, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
